init_mem_writer: RTL and testbench

INIT_MEM_WRITER -- requirements
Module: init_mem_writer

---
 rtl/init_mem_writer_pkg.sv | 31 +++
 rtl/init_mem_writer_sync_fifo.sv | 66 ++++++
 rtl/init_mem_writer.sv | 162 ++++++++++++++++
 tb/tb_init_mem_writer.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/init_mem_writer_pkg.sv
// Shared encodings for the boot-time image writer.
// Sequencer and loader-handshake states plus image size.
package init_mem_writer_pkg;

    typedef enum logic [2:0] {
        SEQ_RESET      = 3'd0,
        SEQ_WAIT_CALIB = 3'd1,
        SEQ_SETTLE     = 3'd2,
        SEQ_LOAD       = 3'd3,
        SEQ_DRAIN      = 3'd4,
        SEQ_DONE       = 3'd5
    } seq_t;

    typedef enum logic [7:0] {
        CTRL_READY   = 8'h00,
        CTRL_ACCEPT  = 8'h01,
        CTRL_FULL    = 8'h02,
        CTRL_BLOCKED = 8'h0F
    } ctrl_t;

    localparam int unsigned BIN_SIZE = 16;

    // Byte address of word n; wraps silently at 2^32.
    function automatic logic [31:0] word_addr(
        input logic [31:0] base,
        input logic [31:0] n
    );
        return base + (n << 2);
    endfunction

endpackage

// File: rtl/init_mem_writer_sync_fifo.sv
// Synchronous word buffer between loader and memory.
// Head word is presented on rdata_o while not empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Storage array; contents need no reset, pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wptr_q <= next_ptr(wptr_q);
            end
            if (pop_ok) begin
                rptr_q <= next_ptr(rptr_q);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/init_mem_writer.sv
// Boot sequencer that streams the SD image into memory.
// Loader words are buffered and written one request at a time.
module init_mem_writer
    import init_mem_writer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned SETTLE_CYC = 256,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk27mhz,
    input  logic        resetn,
    input  logic        mem_calib_done,
    input  logic [31:0] ld_data,
    input  logic        ld_we,
    input  logic        ld_done,
    output logic [7:0]  ctrl_state,
    output logic [2:0]  main_init_state,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic        init_done,
    output logic [31:0] word_count
);

    localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;

    seq_t        seq_q;
    seq_t        seq_d;
    ctrl_t       ctrl_q;
    logic [31:0] settle_q;
    logic        done_seen_q;
    logic        init_done_q;
    logic        mem_req_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] word_count_q;

    logic           fifo_push;
    logic           fifo_pop;
    logic [31:0]    fifo_dout;
    logic           fifo_full;
    logic           fifo_empty;
    logic [FCW-1:0] fifo_count;

    assign fifo_push = (seq_q == SEQ_LOAD) && (ctrl_q == CTRL_READY)
                       && ld_we && !fifo_full;
    assign fifo_pop  = mem_req_q && mem_ack;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk27mhz),
        .rstn_i  (resetn),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (ld_data),
        .rdata_o (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Sequencer next state; DONE is sticky until reset.
    always_comb begin
        seq_d = seq_q;
        unique case (seq_q)
            SEQ_RESET: seq_d = SEQ_WAIT_CALIB;
            SEQ_WAIT_CALIB: begin
                if (mem_calib_done) seq_d = SEQ_SETTLE;
            end
            SEQ_SETTLE: begin
                if (settle_q == SETTLE_CYC - 1) seq_d = SEQ_LOAD;
            end
            SEQ_LOAD: begin
                if (done_seen_q || ld_done) seq_d = SEQ_DRAIN;
            end
            SEQ_DRAIN: begin
                if (fifo_empty && !mem_req_q) seq_d = SEQ_DONE;
            end
            SEQ_DONE: seq_d = SEQ_DONE;
            default:  seq_d = SEQ_RESET;
        endcase
    end

    // Sequencer state, settle timer, early-done latch and init_done flag.
    always_ff @(posedge clk27mhz) begin
        if (!resetn) begin
            seq_q       <= SEQ_RESET;
            settle_q    <= '0;
            done_seen_q <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            seq_q <= seq_d;
            if (seq_q == SEQ_SETTLE && seq_d == SEQ_SETTLE) begin
                settle_q <= settle_q + 32'd1;
            end else begin
                settle_q <= '0;
            end
            if (ld_done) begin
                done_seen_q <= 1'b1;
            end
            init_done_q <= (seq_d == SEQ_DONE);
        end
    end

    // Loader handshake; follows the sequencer's next state so it
    // reads BLOCKED exactly while the sequencer is outside LOAD.
    always_ff @(posedge clk27mhz) begin
        if (!resetn) begin
            ctrl_q <= CTRL_BLOCKED;
        end else if (seq_d != SEQ_LOAD) begin
            ctrl_q <= CTRL_BLOCKED;
        end else if (seq_q != SEQ_LOAD) begin
            ctrl_q <= CTRL_READY;
        end else begin
            unique case (ctrl_q)
                CTRL_READY: begin
                    if (ld_we && !fifo_full) ctrl_q <= CTRL_ACCEPT;
                end
                CTRL_ACCEPT: begin
                    if (!ld_we) begin
                        ctrl_q <= fifo_full ? CTRL_FULL : CTRL_READY;
                    end
                end
                CTRL_FULL: begin
                    if (fifo_count < FCW'(FIFO_DEPTH)) ctrl_q <= CTRL_READY;
                end
                default: ctrl_q <= CTRL_READY;
            endcase
        end
    end

    // Write channel: one request in flight, idle cycle after each ack.
    always_ff @(posedge clk27mhz) begin
        if (!resetn) begin
            mem_req_q    <= 1'b0;
            mem_addr_q   <= BASE_ADDR;
            mem_wdata_q  <= '0;
            word_count_q <= '0;
        end else if (mem_req_q) begin
            if (mem_ack) begin
                mem_req_q    <= 1'b0;
                word_count_q <= word_count_q + 32'd1;
            end
        end else if (!fifo_empty) begin
            mem_req_q   <= 1'b1;
            mem_addr_q  <= word_addr(BASE_ADDR, word_count_q);
            mem_wdata_q <= fifo_dout;
        end
    end

    assign ctrl_state      = ctrl_q;
    assign main_init_state = seq_q;
    assign init_done       = init_done_q;
    assign mem_req         = mem_req_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign word_count      = word_count_q;

endmodule

// File: tb/tb_init_mem_writer.sv
// Randomized bench for init_mem_writer with a queue-based
// reference model of the committed memory image.
`timescale 1ns/1ps
module tb_init_mem_writer;
    import init_mem_writer_pkg::*;

    localparam logic [31:0] TB_BASE   = 32'hFFFF_FFF0;
    localparam int          TB_SETTLE = 16;
    localparam int          TB_DEPTH  = 4;

    logic        clk27mhz = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_calib_done = 1'b0;
    logic [31:0] ld_data = '0;
    logic        ld_we = 1'b0;
    logic        ld_done = 1'b0;
    logic [7:0]  ctrl_state;
    logic [2:0]  main_init_state;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic        init_done;
    logic [31:0] word_count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: words in push order, writes counted by the bench.
    logic [31:0] exp_q[$];
    int          n_commit = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;

    // Memory responder controls.
    logic ack_en = 1'b0;
    logic ack_rand = 1'b0;
    logic ack_force = 1'b0;
    int   ack_dly = 0;
    int   cur_dly = 0;
    int   ack_wait = 0;
    logic p_req = 1'b0;
    logic p_ack = 1'b0;
    logic [31:0] p_addr = '0;
    logic [31:0] p_data = '0;

    init_mem_writer #(
        .BASE_ADDR  (TB_BASE),
        .SETTLE_CYC (TB_SETTLE),
        .FIFO_DEPTH (TB_DEPTH)
    ) dut (
        .clk27mhz        (clk27mhz),
        .resetn          (resetn),
        .mem_calib_done  (mem_calib_done),
        .ld_data         (ld_data),
        .ld_we           (ld_we),
        .ld_done         (ld_done),
        .ctrl_state      (ctrl_state),
        .main_init_state (main_init_state),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .init_done       (init_done),
        .word_count      (word_count)
    );

    initial forever #5 clk27mhz = ~clk27mhz;

    // Memory model: acks after a delay and checks each committed write.
    always @(negedge clk27mhz) begin
        logic        fire;
        logic [31:0] exp_a;
        fire = 1'b0;
        if (!resetn) begin
            ack_wait = 0;
            p_req = 1'b0;
            p_ack = 1'b0;
        end else begin
            if (p_req && mem_req && !p_ack) begin
                vectors++;
                if (mem_addr !== p_addr || mem_wdata !== p_data) begin
                    miscompares++;
                    $display("FAIL req_stable: got %h/%h want %h/%h",
                             mem_addr, mem_wdata, p_addr, p_data);
                end
            end
            if (p_req && p_ack) begin
                vectors++;
                if (mem_req !== 1'b0) begin
                    miscompares++;
                    $display("FAIL req_idle_gap: got mem_req=%b want 0", mem_req);
                end
            end
            if (mem_req === 1'b1 && ack_en) begin
                if (ack_wait >= cur_dly) fire = 1'b1;
                else ack_wait++;
            end else if (mem_req !== 1'b1) begin
                ack_wait = 0;
                cur_dly = ack_rand ? int'($urandom_range(0, 4)) : ack_dly;
            end
            if (fire) begin
                vectors++;
                exp_a = TB_BASE + 32'(n_commit) * 32'd4;
                if (n_commit >= exp_q.size()) begin
                    miscompares++;
                    $display("FAIL mem_write_extra: got %h/%h want no write",
                             mem_addr, mem_wdata);
                end else if (mem_addr !== exp_a || mem_wdata !== exp_q[n_commit]) begin
                    miscompares++;
                    $display("FAIL mem_write[%0d]: got %h/%h want %h/%h",
                             n_commit, mem_addr, mem_wdata, exp_a, exp_q[n_commit]);
                end
                last_addr = mem_addr;
                last_data = mem_wdata;
                n_commit++;
            end
            p_req = mem_req;
            p_ack = fire;
            p_addr = mem_addr;
            p_data = mem_wdata;
        end
        mem_ack = fire | ack_force;
    end

    task automatic do_reset();
        @(negedge clk27mhz);
        resetn = 1'b0;
        ld_we = 1'b0;
        ld_done = 1'b0;
        mem_calib_done = 1'b0;
        ack_force = 1'b0;
        repeat (2) @(negedge clk27mhz);
        exp_q.delete();
        n_commit = 0;
        resetn = 1'b1;
    endtask

    task automatic boot();
        int n;
        do_reset();
        repeat (3) @(negedge clk27mhz);
        mem_calib_done = 1'b1;
        n = 0;
        while (main_init_state !== 3'd3 && n < TB_SETTLE + 50) begin
            @(negedge clk27mhz);
            n++;
        end
        vectors++;
        if (main_init_state !== 3'd3) begin
            miscompares++;
            $display("FAIL boot_load: got state %0d want 3", main_init_state);
        end
    endtask

    // Loader: waits for READY, raises ld_we, holds it hold extra cycles.
    task automatic send_word(input logic [31:0] d, input int hold);
        int n;
        n = 0;
        while (ctrl_state !== 8'h00 && n < 200) begin
            @(negedge clk27mhz);
            n++;
        end
        vectors++;
        if (ctrl_state !== 8'h00) begin
            miscompares++;
            $display("FAIL ld_ready: got ctrl_state %h want 00", ctrl_state);
            return;
        end
        ld_data = d;
        ld_we = 1'b1;
        exp_q.push_back(d);
        @(negedge clk27mhz);
        vectors++;
        if (ctrl_state !== 8'h01) begin
            miscompares++;
            $display("FAIL ld_accept: got ctrl_state %h want 01", ctrl_state);
        end
        repeat (hold) @(negedge clk27mhz);
        ld_we = 1'b0;
        ld_data = $urandom;
        @(negedge clk27mhz);
    endtask

    task automatic wait_commits(input int want, input int budget);
        int n;
        n = 0;
        while ((n_commit < want || mem_req !== 1'b0) && n < budget) begin
            @(negedge clk27mhz);
            n++;
        end
        vectors++;
        if (n_commit != want) begin
            miscompares++;
            $display("FAIL commit_count: got %0d want %0d", n_commit, want);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        ld_we = 1'b1;
        ld_data = $urandom;
        mem_calib_done = 1'b1;
        ld_done = 1'b1;
        repeat (2) @(negedge clk27mhz);
        vectors++;
        if (main_init_state !== 3'd0 || ctrl_state !== 8'h0F || mem_req !== 1'b0
            || mem_addr !== TB_BASE || mem_wdata !== 32'd0
            || word_count !== 32'd0 || init_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values: got st=%0d ctrl=%h req=%b addr=%h wd=%h wc=%0d done=%b want 0/0F/0/%h/0/0/0",
                     main_init_state, ctrl_state, mem_req, mem_addr, mem_wdata,
                     word_count, init_done, TB_BASE);
        end
        ld_we = 1'b0;
        ld_done = 1'b0;
        mem_calib_done = 1'b0;
    endtask

    task automatic test_boot();
        int  n;
        int  bad_ctrl;
        do_reset();
        @(negedge clk27mhz);
        vectors++;
        if (main_init_state !== 3'd1 || ctrl_state !== 8'h0F) begin
            miscompares++;
            $display("FAIL boot_wait_calib: got %0d/%h want 1/0F",
                     main_init_state, ctrl_state);
        end
        repeat (9) @(negedge clk27mhz);
        vectors++;
        if (main_init_state !== 3'd1) begin
            miscompares++;
            $display("FAIL boot_hold_calib: got %0d want 1", main_init_state);
        end
        mem_calib_done = 1'b1;
        @(negedge clk27mhz);
        vectors++;
        if (main_init_state !== 3'd2 || ctrl_state !== 8'h0F) begin
            miscompares++;
            $display("FAIL boot_settle: got %0d/%h want 2/0F",
                     main_init_state, ctrl_state);
        end
        n = 0;
        bad_ctrl = 0;
        while (main_init_state !== 3'd3 && n < TB_SETTLE + 20) begin
            if (ctrl_state !== 8'h0F) bad_ctrl++;
            @(negedge clk27mhz);
            n++;
        end
        vectors++;
        if (n != TB_SETTLE || bad_ctrl != 0) begin
            miscompares++;
            $display("FAIL boot_settle_len: got %0d cycles (%0d unblocked) want %0d (0)",
                     n, bad_ctrl, TB_SETTLE);
        end
        vectors++;
        if (main_init_state !== 3'd3 || ctrl_state !== 8'h00) begin
            miscompares++;
            $display("FAIL boot_load_ready: got %0d/%h want 3/00",
                     main_init_state, ctrl_state);
        end
    endtask

    task automatic test_single_word();
        boot();
        ack_rand = 1'b0;
        ack_dly = 2;
        ack_en = 1'b1;
        send_word(32'hDEADBEEF, 4);
        wait_commits(1, 50);
        repeat (5) @(negedge clk27mhz);
        vectors++;
        if (n_commit != 1 || word_count !== 32'd1) begin
            miscompares++;
            $display("FAIL single_count: got %0d writes wc=%0d want 1/1",
                     n_commit, word_count);
        end
        vectors++;
        if (last_addr !== TB_BASE || last_data !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL single_write: got %h/%h want %h/DEADBEEF",
                     last_addr, last_data, TB_BASE);
        end
    endtask

    task automatic test_backpressure();
        boot();
        ack_en = 1'b0;
        ack_rand = 1'b0;
        ack_dly = 1;
        for (int i = 0; i < 4; i++) send_word($urandom, 0);
        vectors++;
        if (ctrl_state !== 8'h02 || mem_req !== 1'b1 || word_count !== 32'd0) begin
            miscompares++;
            $display("FAIL bp_full: got ctrl=%h req=%b wc=%0d want 02/1/0",
                     ctrl_state, mem_req, word_count);
        end
        vectors++;
        if (mem_addr !== TB_BASE || mem_wdata !== exp_q[0]) begin
            miscompares++;
            $display("FAIL bp_head: got %h/%h want %h/%h",
                     mem_addr, mem_wdata, TB_BASE, exp_q[0]);
        end
        ack_en = 1'b1;
        send_word($urandom, 1);
        wait_commits(5, 200);
        vectors++;
        if (word_count !== 32'd5 || last_addr !== 32'h0000_0000) begin
            miscompares++;
            $display("FAIL bp_wrap: got wc=%0d last=%h want 5/00000000",
                     word_count, last_addr);
        end
    endtask

    task automatic test_completion();
        int n;
        boot();
        ack_rand = 1'b1;
        ack_en = 1'b1;
        for (int i = 0; i < int'(BIN_SIZE / 4); i++) send_word($urandom, $urandom_range(0, 2));
        ld_done = 1'b1;
        @(negedge clk27mhz);
        ld_done = 1'b0;
        vectors++;
        if (main_init_state !== 3'd4 || ctrl_state !== 8'h0F) begin
            miscompares++;
            $display("FAIL done_drain: got %0d/%h want 4/0F",
                     main_init_state, ctrl_state);
        end
        n = 0;
        while (init_done !== 1'b1 && n < 200) begin
            @(negedge clk27mhz);
            n++;
        end
        vectors++;
        if (init_done !== 1'b1 || main_init_state !== 3'd5
            || word_count !== 32'(BIN_SIZE / 4) || n_commit != int'(BIN_SIZE / 4)) begin
            miscompares++;
            $display("FAIL done_final: got done=%b st=%0d wc=%0d wr=%0d want 1/5/%0d/%0d",
                     init_done, main_init_state, word_count, n_commit,
                     BIN_SIZE / 4, BIN_SIZE / 4);
        end
        ld_we = 1'b1;
        ld_data = $urandom;
        repeat (4) @(negedge clk27mhz);
        ld_we = 1'b0;
        vectors++;
        if (main_init_state !== 3'd5 || ctrl_state !== 8'h0F
            || word_count !== 32'(BIN_SIZE / 4) || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL done_sticky: got st=%0d ctrl=%h wc=%0d req=%b want 5/0F/%0d/0",
                     main_init_state, ctrl_state, word_count, mem_req, BIN_SIZE / 4);
        end
    endtask

    task automatic test_early_done();
        int n;
        do_reset();
        repeat (2) @(negedge clk27mhz);
        ld_done = 1'b1;
        @(negedge clk27mhz);
        ld_done = 1'b0;
        repeat (2) @(negedge clk27mhz);
        mem_calib_done = 1'b1;
        n = 0;
        while (main_init_state !== 3'd3 && n < TB_SETTLE + 20) begin
            @(negedge clk27mhz);
            n++;
        end
        @(negedge clk27mhz);
        vectors++;
        if (main_init_state !== 3'd4) begin
            miscompares++;
            $display("FAIL early_done_drain: got %0d want 4", main_init_state);
        end
        @(negedge clk27mhz);
        vectors++;
        if (main_init_state !== 3'd5 || init_done !== 1'b1 || word_count !== 32'd0) begin
            miscompares++;
            $display("FAIL early_done_final: got %0d/%b/%0d want 5/1/0",
                     main_init_state, init_done, word_count);
        end
    endtask

    task automatic test_reset_mid_transfer();
        boot();
        ack_en = 1'b0;
        ack_rand = 1'b0;
        send_word($urandom, 0);
        vectors++;
        if (mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_req: got mem_req=%b want 1", mem_req);
        end
        resetn = 1'b0;
        mem_calib_done = 1'b0;
        @(negedge clk27mhz);
        vectors++;
        if (main_init_state !== 3'd0 || ctrl_state !== 8'h0F || mem_req !== 1'b0
            || mem_addr !== TB_BASE || mem_wdata !== 32'd0
            || word_count !== 32'd0 || init_done !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_values: got st=%0d ctrl=%h req=%b addr=%h wd=%h wc=%0d done=%b",
                     main_init_state, ctrl_state, mem_req, mem_addr, mem_wdata,
                     word_count, init_done);
        end
        exp_q.delete();
        n_commit = 0;
        resetn = 1'b1;
        ack_force = 1'b1;
        repeat (3) @(negedge clk27mhz);
        ack_force = 1'b0;
        mem_calib_done = 1'b1;
        repeat (TB_SETTLE + 6) @(negedge clk27mhz);
        vectors++;
        if (mem_req !== 1'b0 || word_count !== 32'd0 || main_init_state !== 3'd3) begin
            miscompares++;
            $display("FAIL mid_late_ack: got req=%b wc=%0d st=%0d want 0/0/3",
                     mem_req, word_count, main_init_state);
        end
    endtask

    task automatic test_random();
        int nw;
        int n;
        for (int it = 0; it < 6; it++) begin
            boot();
            ack_rand = 1'b1;
            ack_en = 1'b1;
            nw = $urandom_range(1, 10);
            for (int i = 0; i < nw; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk27mhz);
                send_word($urandom, $urandom_range(0, 3));
            end
            ld_done = 1'b1;
            @(negedge clk27mhz);
            ld_done = 1'b0;
            n = 0;
            while (init_done !== 1'b1 && n < 400) begin
                @(negedge clk27mhz);
                n++;
            end
            vectors++;
            if (init_done !== 1'b1 || n_commit != nw || word_count !== 32'(nw)) begin
                miscompares++;
                $display("FAIL random[%0d]: got done=%b wr=%0d wc=%0d want 1/%0d/%0d",
                         it, init_done, n_commit, word_count, nw, nw);
            end
        end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_single_word();
        test_backpressure();
        test_completion();
        test_early_done();
        test_reset_mid_transfer();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
